clip_excess_calc: RTL and testbench
===================================

# clip_excess_calc

Per-block histogram clipper for the CLAHE pipeline, sitting directly upstream of the 32-entry per-block excess RAM. On a start pulse it scans the 256-bin histogram of one block and clips each bin at `clip_limit`. It accumulates the total clipped-off count with saturation, optionally writes the clipped bins back, then writes the 16-bit excess total into the excess RAM at the block's address. The redistribution stage later reads that RAM four blocks at a time.

## Interface
- `NUM_BINS`, 256: bins per block histogram; address width is log2(NUM_BINS).
- `BIN_W`, 16: histogram bin width.
- `BLK_W`, 5: block index width (32 blocks).
- `EXC_W`, 16: excess value width; must equal `BIN_W`.

Ports:
- `clk` in 1: the single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `block_idx` in BLK_W: block to process; latched on accepted start.
- `clip_limit` in BIN_W: clip threshold; latched on accepted start.
- `busy` out 1: high from the cycle after an accepted start through the excess write cycle.
- `done` out 1: one-cycle completion pulse.
- `hist_rd_en` out 1: histogram RAM read enable.
- `hist_rd_addr` out 8: histogram RAM read address.
- `hist_rd_data` in BIN_W: histogram RAM read data, valid the cycle after `hist_rd_en`.
- `hist_wr_en` out 1: clipped-bin writeback enable.
- `hist_wr_addr` out 8: writeback address.
- `hist_wr_data` out BIN_W: clipped bin value.
- `excess_addr` out BLK_W: excess RAM write address, equal to the latched `block_idx`.
- `excess_wr_data` out EXC_W: excess total.
- `excess_wren` out 1: excess RAM write enable, exactly one cycle per job.

## Operation
- FSM states are IDLE, SCAN, DRAIN, WRITE and DONE.
- **IDLE**:
  - `start` latches `block_idx` and `clip_limit`.
  - It clears the accumulator and goes to SCAN.
- **SCAN**: issues reads for addresses 0..255, one per cycle, then goes to DRAIN.
- **DRAIN**: waits for the last read data and the final accumulate, then goes to WRITE.
- **WRITE**: asserts `excess_wren` with the final sum, then goes to DONE.
- **DONE**: pulses `done` and returns to IDLE.
- Per bin b:
  - If b > clip, excess += b − clip and the clipped value is clip.
  - Otherwise the clipped value is b and excess is unchanged; b == clip contributes 0.
- The accumulator saturates at 16'hFFFF, using a 17-bit internal add clamped to 16 bits. It never wraps.
- `start` while not in IDLE is ignored; the latched parameters do not change.
- `rst` mid-job:
  - Next cycle, state is IDLE and every output is 0.
  - No `excess_wren` and no `done` are produced for the aborted job.
  - Bins already written back remain as written.
- Reset value of every output is 0.

## Timing
Cycle 0 is the cycle `start` is sampled high in IDLE.
- Cycles 1..256: `hist_rd_en`=1 and `hist_rd_addr`=k in cycle k+1; `busy`=1.
- Cycles 2..257: data for bin k is on `hist_rd_data` in cycle k+2.
- Cycles 3..258: writeback of bin k is registered in cycle k+3.
- Cycle 258: `excess_wren`=1 with the saturated total and `excess_addr`=latched block.
- Cycle 259: `done`=1 and `busy`=0. A new `start` in cycle 259 is accepted.
- Throughput is one job per 259 cycles.
- The read and write addresses never coincide in the same cycle, so a simple dual-port histogram RAM suffices.

## Configuration
- `CLAHE_CLIP_WRITEBACK_EN`:
  - **Defined**: clipped bins are written back as specified; `hist_wr_*` are active.
  - **Undefined**: `hist_wr_en`, `hist_wr_addr` and `hist_wr_data` are tied to 0 and the histogram is left unclipped, so the downstream CDF stage clips on the fly. Excess computation and timing are unchanged.

## Structure
- The shared package `clahe_pkg` holds:
  - `NUM_BINS`, `BIN_W`, `BLK_W`, `EXC_W`;
  - the FSM state enum;
  - the `EXC_SAT` constant (16'hFFFF).
- One sub-module, `excess_sat_accum`, contains the compare/subtract, the clipped value output and the saturating accumulator register with a clear input. It is instantiated once.

## Test plan
- All bins 10, clip 20, block 3 -> `excess_wren` in cycle 258, addr 3, data 0; all 256 writebacks are 10; `done` in cycle 259.
- Bin 5 = 100, others 0, clip 40, block 31 -> excess 60; writeback bin 5 = 40, others 0.
- All bins 0xFFFF, clip 0 -> excess saturates at 0xFFFF; all writebacks 0.
- All bins 50, clip 50 -> excess 0; writebacks 50.
- `start` again at cycles 10 and 258 -> ignored, a single excess write; `start` at cycle 259 -> second job runs with the newly latched block.
- `rst` at cycle 100 -> cycle 101 is idle with all outputs 0; `excess_wren` and `done` never assert; a following `start` runs normally.
- Build without `CLAHE_CLIP_WRITEBACK_EN` -> `hist_wr_en` is constantly 0; excess values are identical to the cases above.

Source files
------------

// File: rtl/clahe_pkg.sv
// ---------------------------------------------------------------------------
// clahe_pkg
// Shared definitions for the CLAHE histogram clipping stage.
//   NUM_BINS : bins per block histogram
//   BIN_W    : histogram bin width
//   BLK_W    : block index width (32 blocks)
//   EXC_W    : excess total width (equal to BIN_W)
//   ADDR_W   : histogram address width, log2(NUM_BINS)
//   EXC_SAT  : saturation value of the excess accumulator
//   state_t  : clipper FSM states
// ---------------------------------------------------------------------------
package clahe_pkg;

    localparam int NUM_BINS = 256;
    localparam int BIN_W    = 16;
    localparam int BLK_W    = 5;
    localparam int EXC_W    = 16;
    localparam int ADDR_W   = $clog2(NUM_BINS);

    localparam logic [EXC_W-1:0] EXC_SAT = {EXC_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/clip_excess_calc_if.sv
// ---------------------------------------------------------------------------
// clip_excess_calc_if
// Bundles the job handshake, the histogram RAM ports and the excess RAM
// write port of the clipper.
//   master : job requester / RAM side (drives start, block_idx, clip_limit,
//            hist_rd_data)
//   slave  : the clipper itself
// ---------------------------------------------------------------------------
interface clip_excess_calc_if;
    import clahe_pkg::*;

    // job handshake
    logic                 start;
    logic [BLK_W-1:0]     block_idx;
    logic [BIN_W-1:0]     clip_limit;
    logic                 busy;
    logic                 done;

    // histogram RAM read port
    logic                 hist_rd_en;
    logic [ADDR_W-1:0]    hist_rd_addr;
    logic [BIN_W-1:0]     hist_rd_data;

    // histogram RAM clipped-bin writeback port
    logic                 hist_wr_en;
    logic [ADDR_W-1:0]    hist_wr_addr;
    logic [BIN_W-1:0]     hist_wr_data;

    // excess RAM write port
    logic [BLK_W-1:0]     excess_addr;
    logic [EXC_W-1:0]     excess_wr_data;
    logic                 excess_wren;

    modport master (
        output start, block_idx, clip_limit, hist_rd_data,
        input  busy, done,
        input  hist_rd_en, hist_rd_addr,
        input  hist_wr_en, hist_wr_addr, hist_wr_data,
        input  excess_addr, excess_wr_data, excess_wren
    );

    modport slave (
        input  start, block_idx, clip_limit, hist_rd_data,
        output busy, done,
        output hist_rd_en, hist_rd_addr,
        output hist_wr_en, hist_wr_addr, hist_wr_data,
        output excess_addr, excess_wr_data, excess_wren
    );

endinterface

// File: rtl/excess_sat_accum.sv
// ---------------------------------------------------------------------------
// excess_sat_accum
// Clips one histogram bin against the clip limit and accumulates the
// clipped-off amount into a saturating excess total.
//   clk, rst    : clock, synchronous active-high reset
//   clr         : clears the accumulator (new job)
//   en          : bin is valid this cycle; accumulate its excess
//   bin         : current histogram bin value
//   clip_limit  : clip threshold for the current job
//   clipped     : min(bin, clip_limit), combinational
//   acc         : running excess total, clamped at EXC_SAT
// ---------------------------------------------------------------------------
module excess_sat_accum
    import clahe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [BIN_W-1:0] bin,
    input  logic [BIN_W-1:0] clip_limit,
    output logic [BIN_W-1:0] clipped,
    output logic [EXC_W-1:0] acc
);

    logic             over;
    logic [BIN_W-1:0] diff;
    logic [EXC_W:0]   sum;

    // A bin equal to the limit contributes nothing, hence strict compare.
    always_comb begin
        over    = bin > clip_limit;
        diff    = over ? (bin - clip_limit) : '0;
        clipped = over ? clip_limit : bin;
        // One guard bit catches the carry; on carry the total clamps.
        sum     = {1'b0, acc} + {1'b0, diff};
    end

    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum[EXC_W] ? EXC_SAT : sum[EXC_W-1:0];
        end
    end

endmodule

// File: rtl/clip_excess_calc.sv
// ---------------------------------------------------------------------------
// clip_excess_calc
// Per-block histogram clipper of the CLAHE pipeline. On start it scans all
// NUM_BINS bins of one block, clips each at clip_limit, accumulates the
// clipped-off total with saturation and writes that total into the excess
// RAM at the block's address. One job takes 259 cycles.
//
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : clip_excess_calc_if.slave (start/block_idx/clip_limit handshake,
//          busy/done status, histogram read and writeback ports, excess
//          RAM write port)
//
// Build option:
//   CLAHE_CLIP_WRITEBACK_EN defined   -> clipped bins are written back
//   CLAHE_CLIP_WRITEBACK_EN undefined -> hist_wr_* tied to 0
// ---------------------------------------------------------------------------
module clip_excess_calc
    import clahe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    clip_excess_calc_if.slave   bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

    state_t            state_q;
    state_t            state_d;
    logic              accept;

    logic [BLK_W-1:0]  block_q;
    logic [BIN_W-1:0]  clip_q;
    logic [ADDR_W-1:0] rd_addr_q;     // scan counter / read address
    logic              rd_valid_q;    // hist_rd_data carries a bin this cycle
    logic [ADDR_W-1:0] data_addr_q;   // bin index of hist_rd_data

    logic [BIN_W-1:0]  clipped;
    logic [EXC_W-1:0]  acc;

    // DONE can take a new job so that back-to-back jobs run every 259
    // cycles; the done pulse is still emitted for the finishing job.
    assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and outputs (Moore on state_q, so reset forces all 0)
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d            = state_q;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;
        bus.hist_rd_en     = 1'b0;
        bus.hist_rd_addr   = '0;
        bus.excess_wren    = 1'b0;
        bus.excess_wr_data = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                bus.busy         = 1'b1;
                bus.hist_rd_en   = 1'b1;
                bus.hist_rd_addr = rd_addr_q;
                if (rd_addr_q == LAST_ADDR) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // last bin's data is on the bus and accumulates this cycle
                bus.busy = 1'b1;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                bus.busy           = 1'b1;
                bus.excess_wren    = 1'b1;
                bus.excess_wr_data = acc;
                state_d            = ST_DONE;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = accept ? ST_SCAN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Job parameters, scan counter and read-data tracking
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            block_q     <= '0;
            clip_q      <= '0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            data_addr_q <= '0;
        end else begin
            // RAM returns data one cycle after the read was issued.
            rd_valid_q  <= (state_q == ST_SCAN);
            data_addr_q <= rd_addr_q;
            if (accept) begin
                block_q   <= bus.block_idx;
                clip_q    <= bus.clip_limit;
                rd_addr_q <= '0;
            end else if (state_q == ST_SCAN) begin
                // wraps to 0 after the last bin, ready for the next job
                rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
        end
    end

    assign bus.excess_addr = block_q;

    // -----------------------------------------------------------------------
    // Clip and saturating accumulate
    // -----------------------------------------------------------------------
    excess_sat_accum u_accum (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept),
        .en         (rd_valid_q),
        .bin        (bus.hist_rd_data),
        .clip_limit (clip_q),
        .clipped    (clipped),
        .acc        (acc)
    );

    // -----------------------------------------------------------------------
    // Clipped-bin writeback, one cycle behind the data. The write address
    // trails the read address by two, so the RAM never sees both ports on
    // the same bin.
    // -----------------------------------------------------------------------
`ifdef CLAHE_CLIP_WRITEBACK_EN
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [BIN_W-1:0]  wr_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= rd_valid_q;
            if (rd_valid_q) begin
                wr_addr_q <= data_addr_q;
                wr_data_q <= clipped;
            end
        end
    end

    assign bus.hist_wr_en   = wr_en_q;
    assign bus.hist_wr_addr = wr_addr_q;
    assign bus.hist_wr_data = wr_data_q;
`else
    // Histogram stays unclipped; the CDF stage clips on the fly.
    logic unused_clipped;
    assign unused_clipped   = ^clipped;

    assign bus.hist_wr_en   = 1'b0;
    assign bus.hist_wr_addr = '0;
    assign bus.hist_wr_data = '0;
`endif

endmodule

// File: tb/tb_clip_excess_calc.sv
// ---------------------------------------------------------------------------
// tb_clip_excess_calc
// Self-checking bench for clip_excess_calc. A behavioural histogram RAM
// answers reads; a scoreboard holds the expected excess write of each job
// and is popped whenever excess_wren is seen. Writeback expectations depend
// on CLAHE_CLIP_WRITEBACK_EN.
// ---------------------------------------------------------------------------
module tb_clip_excess_calc;
    import clahe_pkg::*;

    typedef struct {
        logic [BLK_W-1:0] blk;
        logic [EXC_W-1:0] exc;
        int               due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clip_excess_calc_if bus ();

    clip_excess_calc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- histogram RAM model and cycle counter ----------------
    logic [BIN_W-1:0] hist [NUM_BINS];
    logic [BIN_W-1:0] wb   [NUM_BINS];
    int cyc      = 0;
    int wb_count = 0;
    int collide  = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.hist_rd_en) bus.hist_rd_data <= hist[bus.hist_rd_addr];
        if (bus.hist_wr_en) begin
            wb[bus.hist_wr_addr] <= bus.hist_wr_data;
            wb_count <= wb_count + 1;
        end
        if (bus.hist_rd_en && bus.hist_wr_en && (bus.hist_rd_addr == bus.hist_wr_addr))
            collide <= collide + 1;
    end

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor on the excess RAM port ------------
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.excess_wren === 1'b1) begin
            if (sb.size() == 0) begin
                check("excess_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("excess_cycle", cyc, e.due);
                check("excess_addr", bus.excess_addr, e.blk);
                check("excess_data", bus.excess_wr_data, e.exc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic fill(input logic [BIN_W-1:0] v);
        for (int i = 0; i < NUM_BINS; i++) hist[i] = v;
    endtask

    task automatic fill_rand(input int lo, input int hi);
        for (int i = 0; i < NUM_BINS; i++) hist[i] = BIN_W'($urandom_range(hi, lo));
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Starts a job at the current negedge and follows it through cycle 259.
    // With noise, extra starts (different block, clip 0) appear at cycles
    // 10 and 258 and must be ignored.
    task automatic run_job(input string name, input logic [BLK_W-1:0] blk,
                           input logic [BIN_W-1:0] clip, input bit noise);
        exp_t e;
        int   sum, t0, wb_base, e_rd, e_busy, e_done, e_wr, e_val;
        bit   exp_rd, exp_wr;
        logic [BIN_W-1:0] want;

        sum = 0;
        for (int i = 0; i < NUM_BINS; i++)
            if (hist[i] > clip) sum += int'(hist[i]) - int'(clip);
        e.blk = blk;
        e.exc = (sum > 65535) ? 16'hFFFF : EXC_W'(sum);
        t0    = cyc;
        e.due = t0 + 258;
        sb.push_back(e);
        wb_base = wb_count;
        e_rd = 0; e_busy = 0; e_done = 0; e_wr = 0; e_val = 0;

        bus.start      = 1'b1;
        bus.block_idx  = blk;
        bus.clip_limit = clip;

        for (int r = 1; r <= 259; r++) begin
            @(negedge clk);
            bus.start = noise && (r == 10 || r == 258);
            if (noise) begin
                bus.block_idx  = 5'd9;
                bus.clip_limit = '0;
            end
            exp_rd = (r <= 256);
`ifdef CLAHE_CLIP_WRITEBACK_EN
            exp_wr = (r >= 3) && (r <= 258);
`else
            exp_wr = 1'b0;
`endif
            if (bus.hist_rd_en !== exp_rd) e_rd++;
            else if (exp_rd && (bus.hist_rd_addr !== ADDR_W'(r - 1))) e_rd++;
            if (bus.busy !== (r <= 258)) e_busy++;
            if (bus.done !== (r == 259)) e_done++;
            if (bus.hist_wr_en !== exp_wr) e_wr++;
            else if (exp_wr && (bus.hist_wr_addr !== ADDR_W'(r - 3))) e_wr++;
        end
        bus.start = 1'b0;

`ifdef CLAHE_CLIP_WRITEBACK_EN
        for (int i = 0; i < NUM_BINS; i++) begin
            want = (hist[i] > clip) ? clip : hist[i];
            if (wb[i] !== want) e_val++;
        end
        check({name, "/wb_count"}, wb_count - wb_base, 256);
`else
        check({name, "/wb_count"}, wb_count - wb_base, 0);
`endif
        check({name, "/rd_seq_errs"}, e_rd, 0);
        check({name, "/busy_errs"}, e_busy, 0);
        check({name, "/done_errs"}, e_done, 0);
        check({name, "/wr_seq_errs"}, e_wr, 0);
        check({name, "/wb_value_errs"}, e_val, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0, dc;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.block_idx  = '0;
        bus.clip_limit = '0;
        fill('0);
        repeat (3) @(negedge clk);

        check("reset/busy", bus.busy, 0);
        check("reset/done", bus.done, 0);
        check("reset/rd_en", bus.hist_rd_en, 0);
        check("reset/wr_en", bus.hist_wr_en, 0);
        check("reset/excess_wren", bus.excess_wren, 0);
        check("reset/excess_data", bus.excess_wr_data, 0);
        rst = 1'b0;
        idle(2);

        fill(16'd10);
        run_job("all10_clip20", 5'd3, 16'd20, 1'b0);
        idle(3);

        fill('0);
        hist[5] = 16'd100;
        run_job("bin5_clip40", 5'd31, 16'd40, 1'b0);
        idle(3);

        fill(16'hFFFF);
        run_job("sat_clip0", 5'd17, 16'd0, 1'b0);
        idle(3);

        fill(16'd50);
        run_job("equal_clip", 5'd8, 16'd50, 1'b0);
        idle(3);

        fill_rand(0, 3000);
        run_job("random", 5'd22, 16'd1500, 1'b0);
        idle(3);

        // extra starts ignored, then a back-to-back job accepted in cycle 259
        fill_rand(0, 2000);
        run_job("noisy", 5'd5, 16'd1000, 1'b1);
        run_job("chained", 5'd7, 16'd200, 1'b0);
        idle(3);

        // reset in the middle of a job
        fill_rand(100, 400);
        t0 = cyc;
        bus.start      = 1'b1;
        bus.block_idx  = 5'd12;
        bus.clip_limit = 16'd150;
        for (int r = 1; r <= 100; r++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst/cycle", cyc - t0, 101);
        check("rst/busy", bus.busy, 0);
        check("rst/done", bus.done, 0);
        check("rst/rd_en", bus.hist_rd_en, 0);
        check("rst/rd_addr", bus.hist_rd_addr, 0);
        check("rst/wr_en", bus.hist_wr_en, 0);
        check("rst/wr_addr", bus.hist_wr_addr, 0);
        check("rst/wr_data", bus.hist_wr_data, 0);
        check("rst/excess_wren", bus.excess_wren, 0);
        check("rst/excess_addr", bus.excess_addr, 0);
        check("rst/excess_data", bus.excess_wr_data, 0);
        rst = 1'b0;
        dc  = done_cnt;
        idle(300);
        check("rst/no_done", done_cnt - dc, 0);

        run_job("after_rst", 5'd30, 16'd300, 1'b0);
        idle(5);

        check("sb_empty", sb.size(), 0);
        check("rd_wr_collisions", collide, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
